// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, reset fetch address and address helpers for the MIPS pipeline
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: decode control, instruction-memory channel and decode-facing output bundle
interface fetch_stage_if;
   import mips_pkg::*;
   logic               i_IF_pause;
   logic               i_IF_redirect;
   logic [ADDR_W-1:0]  i_IF_target;
   logic               o_IF_imemReq;
   logic [ADDR_W-1:0]  o_IF_imemAddr;
   logic               i_IF_imemReady;
   logic               i_IF_imemRvalid;
   logic [INSTR_W-1:0] i_IF_imemRdata;
   logic               o_IF_valid;
   logic [ADDR_W-1:0]  o_IF_pc;
   logic [INSTR_W-1:0] o_IF_instr;
   logic [ADDR_W-1:0]  o_IF_pcPlus4;

   modport master (
      input  i_IF_pause, i_IF_redirect, i_IF_target, i_IF_imemReady, i_IF_imemRvalid, i_IF_imemRdata,
      output o_IF_imemReq, o_IF_imemAddr, o_IF_valid, o_IF_pc, o_IF_instr, o_IF_pcPlus4
   );
   modport slave (
      output i_IF_pause, i_IF_redirect, i_IF_target, i_IF_imemReady, i_IF_imemRvalid, i_IF_imemRdata,
      input  o_IF_imemReq, o_IF_imemAddr, o_IF_valid, o_IF_pc, o_IF_instr, o_IF_pcPlus4
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order slot queue; slots allocated at request accept, filled in order, popped at head
module fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush_i,
   input  logic               alloc_i,
   input  logic [ADDR_W-1:0]  alloc_pc_i,
   input  logic               fill_i,
   input  logic [INSTR_W-1:0] fill_instr_i,
   input  logic               pop_i,
   output logic               head_valid_o,
   output logic [ADDR_W-1:0]  head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o,
   output logic [CW-1:0]      alloc_cnt_o,
   output logic [CW-1:0]      unfilled_cnt_o
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]      head_q, head_d, tail, fptr;
   logic [CW-1:0]      cnt_q, cnt_d, fcnt_q, fcnt_d;
   logic [ADDR_W-1:0]  pc_q    [DEPTH];
   logic [INSTR_W-1:0] instr_q [DEPTH];

   function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input logic [CW-1:0] off);
      logic [CW:0] s;
      s = (CW+1)'(base) + (CW+1)'(off);
      return (s >= (CW+1)'(DEPTH)) ? PW'(s - (CW+1)'(DEPTH)) : PW'(s);
   endfunction

   // filled slots are always contiguous from the head, so a filled count locates the fill pointer
   assign tail = slot(head_q, cnt_q);
   assign fptr = slot(head_q, fcnt_q);

   // next head pointer and occupancy; flush empties the queue outright
   always_comb begin
      head_d = flush_i ? '0 : pop_i ? slot(head_q, CW'(1)) : head_q;
      cnt_d  = flush_i ? '0 : cnt_q + CW'(alloc_i) - CW'(pop_i);
      fcnt_d = flush_i ? '0 : fcnt_q + CW'(fill_i) - CW'(pop_i);
   end

   // pointer and count registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q <= '0;
         cnt_q  <= '0;
         fcnt_q <= '0;
      end else begin
         head_q <= head_d;
         cnt_q  <= cnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   // slot payload storage; contents are only observed behind the filled count
   always_ff @(posedge clk) begin
      if (alloc_i && !flush_i) pc_q[tail] <= alloc_pc_i;
      if (fill_i && !flush_i) instr_q[fptr] <= fill_instr_i;
   end

   assign head_valid_o   = fcnt_q != '0;
   assign head_pc_o      = pc_q[head_q];
   assign head_instr_o   = instr_q[head_q];
   assign alloc_cnt_o    = cnt_q;
   assign unfilled_cnt_o = cnt_q - fcnt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage; owns the fetch PC, issues credit-limited imem requests, drops stale responses after redirect
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input logic           clk,
   input logic           rstn,
   fetch_stage_if.master bus
);
   logic [ADDR_W-1:0]  pc_q, pc_d, head_pc, out_pc;
   logic [INSTR_W-1:0] head_instr;
   logic [CW-1:0]      drop_q, drop_d, alloc_cnt, unfilled_cnt;
   logic [CW:0]        credit, flush_drop;
   logic               req, accept, err, resp_ok, fill, pop, head_valid;

   // every slot plus every response still to be dropped holds one unit of the in-flight budget
   assign credit     = (CW+1)'(alloc_cnt) + (CW+1)'(drop_q);
   assign req        = rstn && (credit < (CW+1)'(DEPTH));
   assign accept     = req && bus.i_IF_imemReady;
   assign err        = bus.i_IF_imemRvalid && drop_q == '0 && unfilled_cnt == '0;
   assign resp_ok    = bus.i_IF_imemRvalid && !err;
   assign fill       = resp_ok && drop_q == '0 && !bus.i_IF_redirect;
   assign pop        = head_valid && !bus.i_IF_pause && !bus.i_IF_redirect;
   assign flush_drop = (CW+1)'(drop_q) + (CW+1)'(unfilled_cnt) + (CW+1)'(accept) - (CW+1)'(resp_ok);

   // on redirect everything still owed by memory from the old stream becomes drop debt
   always_comb begin
      pc_d   = bus.i_IF_redirect ? word_align(bus.i_IF_target) : accept ? pc_q + 32'd4 : pc_q;
      drop_d = bus.i_IF_redirect ? CW'(flush_drop) : drop_q - CW'(resp_ok && drop_q != '0);
   end

   // fetch PC and drop counter
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rstn) !err);

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk           (clk),
      .rstn          (rstn),
      .flush_i       (bus.i_IF_redirect),
      .alloc_i       (accept && !bus.i_IF_redirect),
      .alloc_pc_i    (pc_q),
      .fill_i        (fill),
      .fill_instr_i  (bus.i_IF_imemRdata),
      .pop_i         (pop),
      .head_valid_o  (head_valid),
      .head_pc_o     (head_pc),
      .head_instr_o  (head_instr),
      .alloc_cnt_o   (alloc_cnt),
      .unfilled_cnt_o(unfilled_cnt)
   );

   assign out_pc            = head_valid ? head_pc : '0;
   assign bus.o_IF_imemReq  = req;
   assign bus.o_IF_imemAddr = pc_q;
   assign bus.o_IF_valid    = head_valid;
   assign bus.o_IF_pc       = out_pc;
   assign bus.o_IF_instr    = head_valid ? head_instr : '0;
   assign bus.o_IF_pcPlus4  = out_pc + 32'd4;
endmodule
